som_frame_ram: RTL and testbench
================================

Name: som_frame_ram

Overview:
- Parametrised single-clock pixel frame store for the SOM datapath; successor to the fixed 24-bit × 256K image RAM.
- Adds per-channel (R/G/B) byte-enable writes and write-first read-during-write.
- Adds a configurable read pipeline, out-of-range flagging and a burst read sequencer.
- Feeds pixel streams to the SOM distance/update stages without the upstream controller generating every address.

Parameters:
- DATA_W, 24: pixel width in bits.
- CH_W, 8: channel width; NCH = DATA_W/CH_W byte-enable lanes. DATA_W must be a multiple of CH_W.
- DEPTH, 262144: number of words.
- ADDR_W, 18: address width; DEPTH ≤ 2^ADDR_W.
- RD_LAT, 1: read latency in cycles, legal values 1 or 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  NCH  per-channel write enable; bit i covers wr_data[i*CH_W +: CH_W].
- rd_en  in  1  single-read strobe.
- rd_addr  in  ADDR_W  single-read address.
- burst_start  in  1  start burst read, one-cycle pulse.
- burst_addr  in  ADDR_W  burst start address.
- burst_len  in  ADDR_W+1  burst word count.
- rd_q  out  DATA_W  read data.
- rd_valid  out  1  rd_q valid this cycle.
- rd_oor  out  1  qualifies rd_valid; the request address was ≥ DEPTH.
- wr_oor  out  1  one-cycle pulse: a write was dropped because wr_addr ≥ DEPTH.
- busy  out  1  burst in progress.
- burst_done  out  1  one-cycle pulse when the last burst address has been issued.

Behaviour:
- Reset: rd_q=0, rd_valid=0, rd_oor=0, wr_oor=0, busy=0, burst_done=0; FSM → IDLE; pipeline valids cleared. Memory contents are not reset.
- Write: on a clk edge with wr_en=1 and wr_addr<DEPTH, lanes with wr_be[i]=1 are updated; other lanes are retained. wr_be=0 is a no-op.
- Write out of range: wr_addr≥DEPTH → no array change; wr_oor=1 on the next cycle.
- Read request source:
  - IDLE: rd_en.
  - BURST: the sequencer; rd_en is ignored and produces no response.
- Read latency: a request issued at edge N gives rd_valid at edge N+RD_LAT. rd_q is stable whenever rd_valid=0 and holds its last valid value.
- Read out of range: address≥DEPTH still produces rd_valid, with rd_oor=1 and rd_q unchanged.
- Read-during-write, same address, same edge: write-first. rd_q shows the merged word (new lanes where wr_be set, old lanes elsewhere).
- Read-during-write, different addresses: fully independent.
- FSM IDLE → BURST: burst_start=1 and burst_len>0. Latch burst_addr into a counter and burst_len into a remaining-count; busy=1 the following cycle.
- FSM BURST: issue one read per cycle at the counter address. Counter increments and wraps to 0 after DEPTH-1, so burst addresses are never out of range. Remaining-count decrements.
- FSM BURST → IDLE: after issuing the request with remaining=1, burst_done pulses that cycle and busy falls next cycle. The final rd_valid follows RD_LAT cycles after the last issue.
- burst_len=0: no reads; burst_done pulses one cycle after burst_start; state stays IDLE.
- burst_len>DEPTH: allowed; addresses wrap and repeat.
- burst_start while BURST: ignored.
- burst_start and rd_en together in IDLE: burst wins; the single read is dropped.
- Writes are accepted during a burst. A burst read of an address written the same cycle follows the write-first rule.
- Reset mid-burst: aborts immediately; no burst_done; in-flight rd_valid is discarded.

Decomposition:
- Package som_ram_pkg:
  - constants IMG_SIZE=262144, PIX_W=24, CH_W=8.
  - default ADDR_W.
  - FSM state enum {IDLE, BURST}.
- Sub-module som_ram_core:
  - storage array, byte-enable write, registered write-first read.
  - no reset on the array.
- Top level holds the FSM, counters, latency pipeline and flags.

Test Plan:
- Write addr 5 data 0xAABBCC wr_be=3'b111; next cycle rd_en addr 5 → rd_valid with rd_q=0xAABBCC at RD_LAT; rd_oor=0.
- Byte-enable: addr 5 holds 0xAABBCC; write 0x112233 wr_be=3'b010 → read returns 0xAA22CC.
- Same-edge write 0x445566 wr_be=3'b111 and read, addr 7 → rd_q=0x445566 (write-first).
- Out of range, DEPTH=16: write addr 20 → wr_oor pulse and array unchanged; read addr 20 → rd_valid=1, rd_oor=1, rd_q holds its previous value.
- Burst, DEPTH=16, burst_addr=14, len=4, memory[i]=i:
  - rd_valid for 4 consecutive cycles with rd_q = 14, 15, 0, 1.
  - burst_done pulses on the 4th issue; busy high for 4 cycles.
  - an rd_en asserted mid-burst gets no response.
- burst_len=0 → single burst_done pulse, busy stays 0, no rd_valid. Reset asserted in the 2nd burst cycle → all outputs 0, no burst_done. Repeat the full suite with RD_LAT=2.

Source files
------------

// File: rtl/som_ram_pkg.sv
// Shared constants and types for the SOM pixel frame store.
package som_ram_pkg;

    localparam int IMG_SIZE   = 262144;
    localparam int PIX_W      = 24;
    localparam int CH_W       = 8;
    localparam int DEF_ADDR_W = 18;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

endpackage

// File: rtl/som_ram_core.sv
// Pixel storage with per-channel write enables and a registered write-first read port.
module som_ram_core #(
    parameter int DATA_W = 24,
    parameter int CH_W   = 8,
    parameter int DEPTH  = 262144,
    parameter int ADDR_W = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/CH_W-1:0]   wbe,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        raddr,
    output logic [DATA_W-1:0]        q
);

    localparam int NCH   = DATA_W / CH_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;

    // Callers only assert we/re for in-range addresses, so the low bits index directly.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (we && wbe[i]) begin
                mem[waddr[IDX_W-1:0]][i*CH_W +: CH_W] <= wdata[i*CH_W +: CH_W];
            end
        end
    end

    // Same-edge write to the read address: enabled lanes bypass the array.
    always_comb begin
        rd_word = mem[raddr[IDX_W-1:0]];
        for (int i = 0; i < NCH; i++) begin
            if (we && (waddr == raddr) && wbe[i]) begin
                rd_word[i*CH_W +: CH_W] = wdata[i*CH_W +: CH_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (re) begin
            q <= rd_word;
        end
    end

endmodule

// File: rtl/som_frame_ram.sv
// Frame store top: single/burst read sequencing, read latency pipeline and range flags.
module som_frame_ram #(
    parameter int DATA_W = som_ram_pkg::PIX_W,
    parameter int CH_W   = som_ram_pkg::CH_W,
    parameter int DEPTH  = som_ram_pkg::IMG_SIZE,
    parameter int ADDR_W = som_ram_pkg::DEF_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/CH_W-1:0]   wr_be,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic                     burst_start,
    input  logic [ADDR_W-1:0]        burst_addr,
    input  logic [ADDR_W:0]          burst_len,
    output logic [DATA_W-1:0]        rd_q,
    output logic                     rd_valid,
    output logic                     rd_oor,
    output logic                     wr_oor,
    output logic                     busy,
    output logic                     burst_done
);

    import som_ram_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    burst_state_t        state, state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W:0]     rem;
    logic                zero_done;
    logic                burst_go;
    logic                req_v, req_oor;
    logic [ADDR_W-1:0]   req_addr;
    logic                wr_ok;
    logic                v1, o1;
    logic [DATA_W-1:0]   core_q;

    assign wr_ok    = ({1'b0, wr_addr} < DEPTH_L);
    assign req_oor  = ({1'b0, req_addr} >= DEPTH_L);
    assign burst_go = (state == IDLE) && burst_start && (burst_len != '0);

    // Burst owns the read port; a simultaneous single read is dropped.
    always_comb begin
        state_nxt = state;
        req_v     = 1'b0;
        req_addr  = rd_addr;
        case (state)
            IDLE: begin
                if (burst_go) begin
                    state_nxt = BURST;
                end else if (rd_en) begin
                    req_v = 1'b1;
                end
            end
            BURST: begin
                req_v    = 1'b1;
                req_addr = cnt;
                if (rem == ONE_L) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state == BURST);
    assign burst_done = ((state == BURST) && (rem == ONE_L)) || zero_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            zero_done <= 1'b0;
            wr_oor    <= 1'b0;
            v1        <= 1'b0;
            o1        <= 1'b0;
        end else begin
            state     <= state_nxt;
            zero_done <= (state == IDLE) && burst_start && (burst_len == '0);
            wr_oor    <= wr_en && !wr_ok;
            v1        <= req_v;
            o1        <= req_v && req_oor;
            if (burst_go) begin
                cnt <= burst_addr;
                rem <= burst_len;
            end else if (state == BURST) begin
                cnt <= ({1'b0, cnt} >= LAST_L) ? '0 : cnt + ADDR_W'(1);
                rem <= rem - ONE_L;
            end
        end
    end

    som_ram_core #(
        .DATA_W (DATA_W),
        .CH_W   (CH_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en && wr_ok),
        .waddr (wr_addr),
        .wdata (wr_data),
        .wbe   (wr_be),
        .re    (req_v && !req_oor),
        .raddr (req_addr),
        .q     (core_q)
    );

    // core_q only moves on in-range reads, so it already holds the last valid word.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign rd_valid = v1;
            assign rd_oor   = o1;
            assign rd_q     = core_q;
        end else begin : g_lat2
            logic              v2, o2;
            logic [DATA_W-1:0] q2;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v2 <= 1'b0;
                    o2 <= 1'b0;
                    q2 <= '0;
                end else begin
                    v2 <= v1;
                    o2 <= o1;
                    if (v1 && !o1) begin
                        q2 <= core_q;
                    end
                end
            end
            assign rd_valid = v2;
            assign rd_oor   = o2;
            assign rd_q     = q2;
        end
    endgenerate

endmodule

// File: tb/tb_som_frame_ram.sv
// Bench for som_frame_ram: RD_LAT=1 and RD_LAT=2 instances share stimulus and one reference model.
module tb_som_frame_ram;

    localparam int DW    = 24;
    localparam int AW    = 5;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic          v;
        logic          o;
        logic [DW-1:0] q;
    } resp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          wr_en, rd_en, burst_start;
    logic [AW-1:0] wr_addr, rd_addr, burst_addr;
    logic [DW-1:0] wr_data;
    logic [2:0]    wr_be;
    logic [AW:0]   burst_len;

    logic [DW-1:0] q1, q2;
    logic          v1, v2, o1, o2, wo1, wo2, b1, b2, d1, d2;

    som_frame_ram #(.DATA_W(DW), .CH_W(8), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .burst_start(burst_start), .burst_addr(burst_addr),
        .burst_len(burst_len), .rd_q(q1), .rd_valid(v1), .rd_oor(o1), .wr_oor(wo1),
        .busy(b1), .burst_done(d1)
    );

    som_frame_ram #(.DATA_W(DW), .CH_W(8), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .burst_start(burst_start), .burst_addr(burst_addr),
        .burst_len(burst_len), .rd_q(q2), .rd_valid(v2), .rd_oor(o2), .wr_oor(wo2),
        .busy(b2), .burst_done(d2)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: array contents, burst progress as address/words-left, and a
    // response history where the newest entry is what latency 1 shows and the one before it latency 2.
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_active;
    int            m_next, m_left;
    logic          m_zero, m_wr_oor;
    logic [DW-1:0] m_q;
    resp_t         m_p1, m_p2;

    task automatic model_reset();
        m_active = 1'b0;
        m_next   = 0;
        m_left   = 0;
        m_zero   = 1'b0;
        m_wr_oor = 1'b0;
        m_q      = '0;
        m_p1     = '0;
        m_p2     = '0;
    endtask

    task automatic model_edge();
        resp_t r;
        logic  req;
        int    a;
        req = 1'b0;
        a   = 0;
        if (m_active) begin
            req = 1'b1;
            a   = m_next;
        end else if (rd_en && !(burst_start && burst_len != 0)) begin
            req = 1'b1;
            a   = int'(rd_addr);
        end
        m_wr_oor = 1'b0;
        if (wr_en) begin
            if (int'(wr_addr) < DEPTH) begin
                for (int l = 0; l < 3; l++)
                    if (wr_be[l]) m_mem[int'(wr_addr)][l*8 +: 8] = wr_data[l*8 +: 8];
            end else begin
                m_wr_oor = 1'b1;
            end
        end
        r = '{v: 1'b0, o: 1'b0, q: m_q};
        if (req) begin
            r.v = 1'b1;
            if (a >= DEPTH) r.o = 1'b1;
            else begin
                m_q = m_mem[a];
                r.q = m_q;
            end
        end
        m_zero = 1'b0;
        if (m_active) begin
            m_next = (m_next + 1) % DEPTH;
            m_left--;
            if (m_left == 0) m_active = 1'b0;
        end else if (burst_start) begin
            if (burst_len == 0) m_zero = 1'b1;
            else begin
                m_active = 1'b1;
                m_next   = int'(burst_addr);
                m_left   = int'(burst_len);
            end
        end
        m_p2 = m_p1;
        m_p1 = r;
    endtask

    task automatic compare_all();
        logic exp_done;
        exp_done = (m_active && m_left == 1) || m_zero;
        check_eq("l1_valid",  32'(v1),  32'(m_p1.v));
        check_eq("l1_oor",    32'(o1),  32'(m_p1.v & m_p1.o));
        check_eq("l1_q",      32'(q1),  32'(m_p1.q));
        check_eq("l1_wr_oor", 32'(wo1), 32'(m_wr_oor));
        check_eq("l1_busy",   32'(b1),  32'(m_active));
        check_eq("l1_done",   32'(d1),  32'(exp_done));
        check_eq("l2_valid",  32'(v2),  32'(m_p2.v));
        check_eq("l2_oor",    32'(o2),  32'(m_p2.v & m_p2.o));
        check_eq("l2_q",      32'(q2),  32'(m_p2.q));
        check_eq("l2_wr_oor", 32'(wo2), 32'(m_wr_oor));
        check_eq("l2_busy",   32'(b2),  32'(m_active));
        check_eq("l2_done",   32'(d2),  32'(exp_done));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        burst_start = 1'b0; burst_addr = '0; burst_len = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [2:0] be);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be;
        tick();
    endtask

    task automatic rd(input int a);
        rd_en = 1'b1; rd_addr = AW'(a);
        tick();
    endtask

    task automatic burst(input int a, input int len);
        burst_start = 1'b1; burst_addr = AW'(a); burst_len = (AW+1)'(len);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        do_reset();

        for (int i = 0; i < DEPTH; i++) wr(i, DW'(i), 3'b111);

        wr(5, 24'hAABBCC, 3'b111);
        rd(5);
        tick();
        wr(5, 24'h112233, 3'b010);
        rd(5);
        tick();

        // same-edge write and read of one address
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 24'h445566; wr_be = 3'b111;
        rd_en = 1'b1; rd_addr = 5'd7;
        tick();
        tick();

        // out of range, then confirm the aliased slot is untouched
        wr(20, 24'hDEAD01, 3'b111);
        rd(20);
        tick();
        rd(4);
        rd(20);
        tick();
        tick();

        // wrapping burst with a single read attempted mid-burst
        burst(14, 4);
        tick();
        rd(3);
        repeat (5) tick();

        burst(0, 0);
        repeat (3) tick();

        // reset during the second burst cycle
        burst(2, 6);
        tick();
        do_reset();
        repeat (3) tick();

        // long burst with writes and an ignored restart
        burst(10, 20);
        for (int i = 0; i < 22; i++) begin
            if (i == 3) begin burst_start = 1'b1; burst_addr = 5'd0; burst_len = 6'd3; end
            if (i % 4 == 1) begin
                wr_en = 1'b1; wr_addr = AW'((11 + i) % DEPTH); wr_data = DW'($urandom); wr_be = 3'b101;
            end
            tick();
        end

        // burst and single read on the same edge
        burst_start = 1'b1; burst_addr = 5'd1; burst_len = 6'd2;
        rd_en = 1'b1; rd_addr = 5'd9;
        tick();
        repeat (4) tick();

        for (int i = 0; i < 400; i++) begin
            wr_en       = ($urandom_range(0, 2) == 0);
            wr_addr     = AW'($urandom_range(0, 19));
            wr_data     = DW'($urandom);
            wr_be       = 3'($urandom_range(0, 7));
            rd_en       = ($urandom_range(0, 1) == 1);
            rd_addr     = AW'($urandom_range(0, 19));
            burst_start = ($urandom_range(0, 15) == 0);
            burst_addr  = AW'($urandom_range(0, 15));
            burst_len   = (AW+1)'($urandom_range(0, 20));
            if (i == 200) begin
                idle_inputs();
                do_reset();
            end else begin
                tick();
            end
        end

        repeat (25) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
